// File: rtl/lightning_pkg.sv
// Shared types and constants for the lightning-bolt vs enemy hit detector.
package lightning_pkg;

  localparam int unsigned COORD_W = 32;
  localparam int unsigned SUM_W   = COORD_W + 1;
  localparam int unsigned HP_W    = 2;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned TIMER_W = 32;
  localparam int unsigned N_BOLTS = 3;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    FLASH = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [HP_W-1:0]    HP_INIT    = 2'd3;
  localparam logic [SCORE_W-1:0] KILL_BONUS = 16'd10;

  // Score addition that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/lightning_hit_detect_if.sv
// Bolt/enemy positions in, collision and enemy status out.
interface lightning_hit_detect_if;
  import lightning_pkg::*;

  logic [COORD_W-1:0] topLeft_x_light_1;
  logic [COORD_W-1:0] topLeft_y_light_1;
  logic [COORD_W-1:0] topLeft_x_light_2;
  logic [COORD_W-1:0] topLeft_y_light_2;
  logic [COORD_W-1:0] topLeft_x_light_3;
  logic [COORD_W-1:0] topLeft_y_light_3;
  logic               in_air_1;
  logic               in_air_2;
  logic               in_air_3;
  logic [COORD_W-1:0] topLeft_x_enemy;
  logic [COORD_W-1:0] topLeft_y_enemy;

  logic               collision_light_1;
  logic               collision_light_2;
  logic               collision_light_3;
  logic               enemy_hit;
  logic [HP_W-1:0]    enemy_hp;
  logic               enemy_alive;
  logic [SCORE_W-1:0] score;

  modport master (
    output topLeft_x_light_1, topLeft_y_light_1,
    output topLeft_x_light_2, topLeft_y_light_2,
    output topLeft_x_light_3, topLeft_y_light_3,
    output in_air_1, in_air_2, in_air_3,
    output topLeft_x_enemy, topLeft_y_enemy,
    input  collision_light_1, collision_light_2, collision_light_3,
    input  enemy_hit, enemy_hp, enemy_alive, score
  );

  modport slave (
    input  topLeft_x_light_1, topLeft_y_light_1,
    input  topLeft_x_light_2, topLeft_y_light_2,
    input  topLeft_x_light_3, topLeft_y_light_3,
    input  in_air_1, in_air_2, in_air_3,
    input  topLeft_x_enemy, topLeft_y_enemy,
    output collision_light_1, collision_light_2, collision_light_3,
    output enemy_hit, enemy_hp, enemy_alive, score
  );

endinterface

// File: rtl/rect_overlap.sv
// Strict axis-aligned overlap of rectangle a (bolt) and rectangle b (enemy).
module rect_overlap
  import lightning_pkg::*;
#(
  parameter int unsigned W_A = 60,
  parameter int unsigned H_A = 30,
  parameter int unsigned W_B = 64,
  parameter int unsigned H_B = 64
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               overlap_c
);

  logic [SUM_W-1:0] ax_w, ay_w, bx_w, by_w;

  assign ax_w = {1'b0, ax};
  assign ay_w = {1'b0, ay};
  assign bx_w = {1'b0, bx};
  assign by_w = {1'b0, by};

  // One extra bit keeps edge sums from wrapping near the top of the coordinate range.
  assign overlap_c = (ax_w < bx_w + SUM_W'(W_B)) &&
                     (bx_w < ax_w + SUM_W'(W_A)) &&
                     (ay_w < by_w + SUM_W'(H_B)) &&
                     (by_w < ay_w + SUM_W'(H_A));

endmodule

// File: rtl/lightning_hit_detect.sv
// Detects bolt hits on the enemy, tracks enemy hp/score and the ALIVE/FLASH/DEAD cycle.
module lightning_hit_detect
  import lightning_pkg::*;
#(
  parameter int unsigned width_lightning = 60,
  parameter int unsigned height_lightning = 30,
  parameter int unsigned width_enemy     = 64,
  parameter int unsigned height_enemy    = 64,
  parameter int unsigned FLASH_CYCLES    = 12_500_000,
  parameter int unsigned RESPAWN_CYCLES  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart_light,
  lightning_hit_detect_if.slave bus
);

  state_t               state_q, state_nxt;
  logic [TIMER_W-1:0]   timer_q, timer_nxt;
  logic [HP_W-1:0]      hp_q, hp_nxt;
  logic [SCORE_W-1:0]   score_q, score_nxt;
  logic                 hit_q, hit_nxt;
  logic                 alive_q, alive_nxt;
  logic [N_BOLTS-1:0]   coll_q, coll_prev_q, coll_nxt;
  logic [N_BOLTS-1:0]   in_air_c, overlap_c;
  logic                 rise_c;

  assign in_air_c = {bus.in_air_3, bus.in_air_2, bus.in_air_1};

  rect_overlap #(.W_A(width_lightning), .H_A(height_lightning),
                 .W_B(width_enemy), .H_B(height_enemy)) u_ov1 (
    .ax(bus.topLeft_x_light_1), .ay(bus.topLeft_y_light_1),
    .bx(bus.topLeft_x_enemy),   .by(bus.topLeft_y_enemy),
    .overlap_c(overlap_c[0])
  );

  rect_overlap #(.W_A(width_lightning), .H_A(height_lightning),
                 .W_B(width_enemy), .H_B(height_enemy)) u_ov2 (
    .ax(bus.topLeft_x_light_2), .ay(bus.topLeft_y_light_2),
    .bx(bus.topLeft_x_enemy),   .by(bus.topLeft_y_enemy),
    .overlap_c(overlap_c[1])
  );

  rect_overlap #(.W_A(width_lightning), .H_A(height_lightning),
                 .W_B(width_enemy), .H_B(height_enemy)) u_ov3 (
    .ax(bus.topLeft_x_light_3), .ay(bus.topLeft_y_light_3),
    .bx(bus.topLeft_x_enemy),   .by(bus.topLeft_y_enemy),
    .overlap_c(overlap_c[2])
  );

  // State register; restart behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || restart_light) begin
      state_q     <= ALIVE;
      timer_q     <= '0;
      hp_q        <= HP_INIT;
      score_q     <= '0;
      hit_q       <= 1'b0;
      alive_q     <= 1'b1;
      coll_q      <= '0;
      coll_prev_q <= '0;
    end else begin
      state_q     <= state_nxt;
      timer_q     <= timer_nxt;
      hp_q        <= hp_nxt;
      score_q     <= score_nxt;
      hit_q       <= hit_nxt;
      alive_q     <= alive_nxt;
      coll_q      <= coll_nxt;
      coll_prev_q <= coll_q;
    end
  end

  // Next-state, collision latching and scoring.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    hp_nxt    = hp_q;
    score_nxt = score_q;
    hit_nxt   = 1'b0;
    coll_nxt  = '0;
    rise_c    = |(coll_q & ~coll_prev_q);

    // A latched collision holds while the bolt is still in the air.
    for (int i = 0; i < int'(N_BOLTS); i++) begin
      coll_nxt[i] = coll_q[i] ? in_air_c[i]
                              : (in_air_c[i] & overlap_c[i] & (state_q != DEAD));
    end

    case (state_q)
      ALIVE: begin
        if (rise_c) begin
          hit_nxt   = 1'b1;
          timer_nxt = '0;
          if (hp_q > HP_W'(1)) begin
            hp_nxt    = hp_q - HP_W'(1);
            score_nxt = sat_add(score_q, SCORE_W'(1));
            state_nxt = FLASH;
          end else begin
            hp_nxt    = '0;
            score_nxt = sat_add(score_q, SCORE_W'(1) + KILL_BONUS);
            state_nxt = DEAD;
          end
        end
      end
      FLASH: begin
        if (timer_q == TIMER_W'(FLASH_CYCLES - 1)) begin
          state_nxt = ALIVE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_q + TIMER_W'(1);
        end
      end
      DEAD: begin
        if (timer_q == TIMER_W'(RESPAWN_CYCLES - 1)) begin
          state_nxt = ALIVE;
          hp_nxt    = HP_INIT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_nxt = ALIVE;
        timer_nxt = '0;
      end
    endcase

    alive_nxt = (state_nxt != DEAD);
  end

  assign bus.collision_light_1 = coll_q[0];
  assign bus.collision_light_2 = coll_q[1];
  assign bus.collision_light_3 = coll_q[2];
  assign bus.enemy_hit         = hit_q;
  assign bus.enemy_hp          = hp_q;
  assign bus.enemy_alive       = alive_q;
  assign bus.score             = score_q;

endmodule

// File: tb/tb_lightning_hit_detect.sv
// Directed bench for lightning_hit_detect with a cycle-level reference model.
module tb_lightning_hit_detect;

  localparam int FC = 4;
  localparam int RC = 8;
  localparam int M_ALIVE = 0;
  localparam int M_FLASH = 1;
  localparam int M_DEAD  = 2;

  logic        clk;
  logic        reset;
  logic        restart_light;
  logic [31:0] bx [3];
  logic [31:0] by [3];
  logic [2:0]  air;
  logic [31:0] ex, ey;

  lightning_hit_detect_if bus();

  assign bus.topLeft_x_light_1 = bx[0];
  assign bus.topLeft_y_light_1 = by[0];
  assign bus.topLeft_x_light_2 = bx[1];
  assign bus.topLeft_y_light_2 = by[1];
  assign bus.topLeft_x_light_3 = bx[2];
  assign bus.topLeft_y_light_3 = by[2];
  assign bus.in_air_1          = air[0];
  assign bus.in_air_2          = air[1];
  assign bus.in_air_3          = air[2];
  assign bus.topLeft_x_enemy   = ex;
  assign bus.topLeft_y_enemy   = ey;

  lightning_hit_detect #(
    .width_lightning(60), .height_lightning(30),
    .width_enemy(64), .height_enemy(64),
    .FLASH_CYCLES(FC), .RESPAWN_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .restart_light(restart_light),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules tracked by edge count since the last state change.
  int       m_hp, m_score, m_mode, m_entry, edge_n;
  bit [2:0] m_coll, m_prev;
  bit       m_hit, m_valid;

  function automatic bit ovl(input int i);
    longint xl = longint'(bx[i]);
    longint yl = longint'(by[i]);
    longint xe = longint'(ex);
    longint ye = longint'(ey);
    return (xl < xe + 64) && (xe < xl + 60) && (yl < ye + 64) && (ye < yl + 30);
  endfunction

  always @(posedge clk) begin : model
    bit       rise;
    bit [2:0] nc;
    edge_n++;
    if (reset || restart_light) begin
      m_mode = M_ALIVE; m_hp = 3; m_score = 0; m_hit = 0;
      m_coll = '0; m_prev = '0; m_entry = edge_n;
    end else begin
      rise = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_coll[i] && !m_prev[i]) rise = 1;
        if (m_coll[i]) nc[i] = air[i];
        else           nc[i] = air[i] && ovl(i) && (m_mode != M_DEAD);
      end
      m_prev = m_coll;
      m_coll = nc;
      m_hit  = 0;
      if (m_mode == M_ALIVE && rise) begin
        m_hit   = 1;
        m_score = m_score + ((m_hp > 1) ? 1 : 11);
        if (m_score > 65535) m_score = 65535;
        if (m_hp > 1) begin m_hp--; m_mode = M_FLASH; end
        else          begin m_hp = 0; m_mode = M_DEAD; end
        m_entry = edge_n;
      end else if (m_mode == M_FLASH && edge_n - m_entry == FC) begin
        m_mode = M_ALIVE; m_entry = edge_n;
      end else if (m_mode == M_DEAD && edge_n - m_entry == RC) begin
        m_mode = M_ALIVE; m_hp = 3; m_entry = edge_n;
      end
    end
    m_valid = 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("m_coll1", 32'(bus.collision_light_1), 32'(m_coll[0]));
      chk("m_coll2", 32'(bus.collision_light_2), 32'(m_coll[1]));
      chk("m_coll3", 32'(bus.collision_light_3), 32'(m_coll[2]));
      chk("m_hit",   32'(bus.enemy_hit), 32'(m_hit));
      chk("m_hp",    32'(bus.enemy_hp), 32'(m_hp));
      chk("m_alive", 32'(bus.enemy_alive), 32'(m_mode != M_DEAD));
      chk("m_score", 32'(bus.score), 32'(m_score));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic place(input int i, input int x, input int y, input bit a);
    bx[i]  = 32'(x);
    by[i]  = 32'(y);
    air[i] = a;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: sequence did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; restart_light = 1'b0;
    ex = 32'd400; ey = 32'd200; air = '0;
    for (int i = 0; i < 3; i++) begin bx[i] = '0; by[i] = '0; end
    tick(2);
    chk("rst_hp", 32'(bus.enemy_hp), 3);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_alive", 32'(bus.enemy_alive), 1);
    chk("rst_hit", 32'(bus.enemy_hit), 0);
    reset = 1'b0;

    // Edge-touching bolt must not collide.
    place(0, 340, 210, 1); tick(2);
    chk("edge_coll1", 32'(bus.collision_light_1), 0);
    chk("edge_hp", 32'(bus.enemy_hp), 3);
    air[0] = 0; tick(1);

    // Single overlapping bolt.
    place(0, 341, 210, 1); tick(1);
    chk("hit1_coll1", 32'(bus.collision_light_1), 1);
    chk("hit1_nohit_yet", 32'(bus.enemy_hit), 0);
    tick(1);
    chk("hit1_pulse", 32'(bus.enemy_hit), 1);
    chk("hit1_hp", 32'(bus.enemy_hp), 2);
    chk("hit1_score", 32'(bus.score), 1);

    // Bolt absorbed during FLASH does no damage.
    air[0] = 0; place(1, 341, 210, 1); tick(1);
    chk("drop_coll1", 32'(bus.collision_light_1), 0);
    chk("flash_coll2", 32'(bus.collision_light_2), 1);
    air[1] = 0; tick(1);
    chk("flash_nohit", 32'(bus.enemy_hit), 0);
    chk("flash_hp", 32'(bus.enemy_hp), 2);
    tick(1);

    // Collision rising right at FLASH exit is damaging.
    place(2, 341, 210, 1); tick(1);
    chk("exit_coll3", 32'(bus.collision_light_3), 1);
    air[2] = 0; tick(1);
    chk("exit_hit", 32'(bus.enemy_hit), 1);
    chk("exit_hp", 32'(bus.enemy_hp), 1);
    chk("exit_score", 32'(bus.score), 2);
    tick(4);

    // Kill, then an overlapping bolt in DEAD, then restart.
    place(0, 341, 210, 1); tick(2);
    chk("kill_hp", 32'(bus.enemy_hp), 0);
    chk("kill_score", 32'(bus.score), 13);
    chk("kill_alive", 32'(bus.enemy_alive), 0);
    place(1, 341, 210, 1); tick(2);
    chk("dead_coll2", 32'(bus.collision_light_2), 0);
    chk("dead_hold_coll1", 32'(bus.collision_light_1), 1);
    restart_light = 1'b1; tick(1);
    restart_light = 1'b0; air = '0;
    chk("rs_score", 32'(bus.score), 0);
    chk("rs_hp", 32'(bus.enemy_hp), 3);
    chk("rs_alive", 32'(bus.enemy_alive), 1);
    chk("rs_coll1", 32'(bus.collision_light_1), 0);
    chk("rs_coll2", 32'(bus.collision_light_2), 0);
    tick(1);

    // Two simultaneous bolts make one damaging event.
    place(0, 341, 210, 1); place(1, 380, 230, 1); tick(1);
    chk("dual_coll1", 32'(bus.collision_light_1), 1);
    chk("dual_coll2", 32'(bus.collision_light_2), 1);
    air[0] = 0; tick(1);
    chk("dual_hit", 32'(bus.enemy_hit), 1);
    chk("dual_hp", 32'(bus.enemy_hp), 2);
    chk("dual_clear1", 32'(bus.collision_light_1), 0);
    chk("dual_keep2", 32'(bus.collision_light_2), 1);
    tick(1);
    chk("dual_single", 32'(bus.enemy_hit), 0);
    air[1] = 0; tick(4);

    // Two more hits to kill, then respawn timing.
    place(0, 341, 210, 1); tick(1); air[0] = 0; tick(1);
    chk("h2_hp", 32'(bus.enemy_hp), 1);
    tick(5);
    place(0, 341, 210, 1); tick(1); air[0] = 0; tick(1);
    chk("k2_score", 32'(bus.score), 13);
    chk("k2_alive", 32'(bus.enemy_alive), 0);
    place(2, 341, 210, 1); tick(3);
    chk("k2_dead_coll3", 32'(bus.collision_light_3), 0);
    air[2] = 0; tick(4);
    chk("respawn_early", 32'(bus.enemy_alive), 0);
    tick(1);
    chk("respawn_alive", 32'(bus.enemy_alive), 1);
    chk("respawn_hp", 32'(bus.enemy_hp), 3);

    // Reset mid-FLASH leaves no residual invulnerability.
    place(0, 341, 210, 1); tick(1); air[0] = 0; tick(1);
    chk("pre_rst_score", 32'(bus.score), 14);
    tick(2);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("midflash_rst_hp", 32'(bus.enemy_hp), 3);
    place(0, 341, 210, 1); tick(1); air[0] = 0; tick(1);
    chk("post_rst_hit", 32'(bus.enemy_hit), 1);
    chk("post_rst_score", 32'(bus.score), 1);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lightning_hit_detect.md
LIGHTNING_HIT_DETECT -- requirements
Module: lightning_hit_detect

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- width_lightning, 60, bolt width in px
- height_lightning, 30, bolt height in px
- width_enemy / height_enemy, 64 / 64, enemy box size in px
- FLASH_CYCLES, 12_500_000, invulnerable time after a non-fatal hit
- RESPAWN_CYCLES, 50_000_000, time spent in the dead state
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  sync active-high reset
- restart_light  in  1  game restart, same effect as reset
- topLeft_x_light_1..3  in  32 each  bolt top-left x
- topLeft_y_light_1..3  in  32 each  bolt top-left y
- in_air_1..3  in  1 each  bolt active, driven by the bolt mover
- topLeft_x_enemy / topLeft_y_enemy  in  32 each  enemy top-left
- collision_light_1..3  out  1 each  bolt absorbed, consumed by the bolt mover
- enemy_hit  out  1  one-cycle pulse per damaging hit
- enemy_hp  out  2  remaining hit points
- enemy_alive  out  1  high in ALIVE and FLASH
- score  out  16  accumulated points

Function
REQ-004 Overlap_N SHALL be true when all of these hold: xl < xe+width_enemy, xe < xl+width_lightning, yl < ye+height_enemy, ye < yl+height_lightning.
REQ-005 All sums in REQ-004 SHALL be computed 33 bits wide and unsigned, so no wrap-around occurs.
REQ-006 collision_light_N SHALL rise one clock after a cycle in which in_air_N is high, overlap_N is true and the state is not DEAD.
REQ-007 Once set, collision_light_N SHALL stay high until the first clock at which in_air_N is sampled low, then clear on the next edge.
REQ-008 A damaging event SHALL be any cycle in which at least one collision_light_N has a rising edge while the state is ALIVE.
REQ-009 Several simultaneous rising edges SHALL count as a single damaging event.
REQ-010 The state machine SHALL have three states: ALIVE, FLASH and DEAD.
REQ-011 ALIVE SHALL handle a damaging event as follows:
- enemy_hit pulses for one cycle and score increases by 1
- if enemy_hp > 1, enemy_hp decrements and the state goes to FLASH with the timer cleared
- if enemy_hp == 1, enemy_hp becomes 0, score increases by a further KILL_BONUS (11 total), and the state goes to DEAD with the timer cleared
REQ-012 FLASH SHALL still absorb bolts (collision asserted per REQ-006), cause no damage, and return to ALIVE when the timer reaches FLASH_CYCLES-1.
REQ-013 DEAD SHALL assert no new collisions, hold enemy_alive low, and go to ALIVE with enemy_hp=HP_INIT when the timer reaches RESPAWN_CYCLES-1.
REQ-014 Score SHALL saturate at 16'hFFFF and never wrap.
REQ-015 A single shared 32-bit timer SHALL count only in FLASH and DEAD and SHALL be cleared on every state entry.

Reset
REQ-016 reset or restart_light SHALL, on the next clock edge, force: state ALIVE, enemy_hp=HP_INIT (3), score=0, timer=0, all collision_light_N=0, enemy_hit=0, enemy_alive=1.
REQ-017 reset SHALL take priority over restart_light.
REQ-018 reset asserted mid-FLASH or mid-DEAD SHALL abort the timer with no carry-over.

Structure
REQ-019 Package lightning_pkg SHALL hold the state enum (ALIVE, FLASH, DEAD), HP_INIT=3 and KILL_BONUS=10.
REQ-020 The overlap test SHALL be a combinational sub-module, rect_overlap, instantiated three times.

Verification (width_enemy=height_enemy=64, FLASH_CYCLES=4, RESPAWN_CYCLES=8, enemy at (400,200))
REQ-021 Bolt1 at (341,210) with in_air_1=1 -> collision_light_1 high the next cycle, enemy_hit pulse, hp 3->2, score=1.
REQ-022 Bolt1 at (340,210) (touching edge only) -> no collision, hp stays 3.
REQ-023 Bolts 1 and 2 overlapping in the same cycle -> both collisions high, one enemy_hit, hp 3->2; in_air_1 dropped -> collision_light_1 clears on the next edge.
REQ-024 Bolt hit during FLASH -> collision high, no enemy_hit, hp unchanged; ALIVE again 4 cycles after FLASH entry.
REQ-025 Three separated hits -> hp 0, score=13, enemy_alive=0; an overlapping bolt in DEAD gets no collision; after 8 cycles hp=3 and alive=1.
REQ-026 Assert restart_light mid-DEAD with score=13 -> next cycle score=0, hp=3, ALIVE, all collisions low.
